// File: rtl/addr_sweep_ctrl.sv
// addr_sweep_ctrl: sweeps a lookup memory over a wrapping address range
// [first_addr .. last_addr], captures each registered read beat and reports
// the beat count (and optionally an XOR checksum) when the sweep completes.
//
// Optional feature macro: SWEEP_CHECKSUM_EN
//   defined   -> checksum is the XOR of every beat captured in the sweep
//   undefined -> checksum is tied to zero and no register is built
//
// state | meaning
// IDLE  | waiting for start; outputs of last sweep are held
// ISSUE | en=1, one read address per cycle until last_addr is issued
// WAIT  | en=0, last read is still in the memory / capture pipeline
// DONE  | last beat presented together with done; back to IDLE next

module addr_sweep_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic              en,
    output logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] rd_data,
    output logic              data_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic              rd_pend_q;
    logic              valid_q;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              sweep_start;

    assign sweep_start = (state_q == S_IDLE) && start;

    // Next-state and address counter; the counter wraps naturally at 2^ADDR_W.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    addr_d  = first_addr;
                    last_d  = last_addr;
                end
            end
            S_ISSUE: begin
                if (addr_q == last_q) begin
                    state_d = S_WAIT;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            S_WAIT:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Capture path: a read issued in cycle T is sampled at the end of T+1.
    always_comb begin
        data_d  = data_q;
        count_d = count_q;
        if (sweep_start) begin
            count_d = '0;
        end else if (rd_pend_q) begin
            data_d  = rd_data;
            count_d = count_q + (ADDR_W+1)'(1);
        end
    end

    // Control and capture registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            last_q    <= '0;
            rd_pend_q <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            last_q    <= last_d;
            rd_pend_q <= (state_q == S_ISSUE);
            valid_q   <= rd_pend_q;
            data_q    <= data_d;
            count_q   <= count_d;
        end
    end

`ifdef SWEEP_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;

    // Running XOR of captured beats, restarted on each accepted sweep.
    always_comb begin
        sum_d = sum_q;
        if (sweep_start) begin
            sum_d = '0;
        end else if (rd_pend_q) begin
            sum_d = sum_q ^ rd_data;
        end
    end

    // Checksum register.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

    assign en         = (state_q == S_ISSUE);
    assign address    = addr_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign data_valid = valid_q;
    assign data_out   = data_q;
    assign count      = count_q;

endmodule

// File: tb/tb_addr_sweep_ctrl.sv
// Bench for addr_sweep_ctrl: spec vector table, randomized sweeps against a
// range/array reference model, plus start-while-busy and mid-sweep reset.

module tb_addr_sweep_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] first_addr;
    logic [3:0] last_addr;
    logic       en;
    logic [3:0] address;
    logic [7:0] rd_data;
    logic       data_valid;
    logic [7:0] data_out;
    logic       busy;
    logic       done;
    logic [4:0] count;
    logic [7:0] checksum;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem_arr [16];
    logic [3:0] got_addr [$];
    logic [7:0] got_beat [$];
    int         res_count;
    logic [7:0] res_sum;

    typedef struct {
        logic [3:0] first;
        logic [3:0] last;
        int         exp_n;
        logic [7:0] exp_sum;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    addr_sweep_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .en         (en),
        .address    (address),
        .rd_data    (rd_data),
        .data_valid (data_valid),
        .data_out   (data_out),
        .busy       (busy),
        .done       (done),
        .count      (count),
        .checksum   (checksum)
    );

    // Registered-output memory; garbage when not enabled.
    always @(posedge clk) begin
        if (en) rd_data <= mem_arr[address];
        else    rd_data <= 8'($urandom);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic spec_mem();
        for (int i = 0; i < 16; i++) mem_arr[i] = 8'hFF;
        mem_arr[0]  = 8'h00;
        mem_arr[1]  = 8'h01;
        mem_arr[15] = 8'h0F;
    endtask

    function automatic int model_len(input logic [3:0] f, input logic [3:0] l);
        return ((int'(l) - int'(f) + 16) % 16) + 1;
    endfunction

    function automatic logic [7:0] model_sum(input logic [3:0] f, input logic [3:0] l);
        logic [7:0] s;
        s = 8'h00;
`ifdef SWEEP_CHECKSUM_EN
        for (int i = 0; i < model_len(f, l); i++) s = s ^ mem_arr[(int'(f) + i) % 16];
`endif
        return s;
    endfunction

    // One sweep from IDLE; compares against the model and returns count/checksum.
    task automatic run_sweep(input logic [3:0] f, input logic [3:0] l,
                             input bit hold_start, input string tag);
        int cyc, n, en_first, en_last, dv_first, dv_last, done_cyc, n_done;
        bit mism;
        n = model_len(f, l);
        got_addr.delete();
        got_beat.delete();
        en_first = -1; en_last = -1; dv_first = -1; dv_last = -1;
        done_cyc = -1; n_done = 0;
        first_addr = f;
        last_addr  = l;
        start      = 1'b1;
        tick();
        start = hold_start;
        cyc = 0;
        while (cyc < 60) begin
            if (en) begin
                if (en_first < 0) en_first = cyc;
                en_last = cyc;
                got_addr.push_back(address);
            end
            if (data_valid) begin
                if (dv_first < 0) dv_first = cyc;
                dv_last = cyc;
                got_beat.push_back(data_out);
                chk({tag, " count_step"}, 32'(count), 32'(got_beat.size()));
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) break;
            tick();
            cyc++;
        end
        chk({tag, " timeout"}, 32'(done_cyc >= 0), 32'd1);
        chk({tag, " busy_after_done"}, 32'(busy), 32'd0);
        start = 1'b0;
        chk({tag, " en_start_cycle"}, 32'(en_first), 32'd0);
        chk({tag, " en_cycles"}, 32'(got_addr.size()), 32'(n));
        chk({tag, " en_contig"}, 32'(en_last - en_first + 1), 32'(n));
        mism = (got_addr.size() != n) || (got_beat.size() != n);
        for (int i = 0; i < n && !mism; i++) begin
            if (got_addr[i] !== 4'((int'(f) + i) % 16)) mism = 1'b1;
            if (got_beat[i] !== mem_arr[(int'(f) + i) % 16]) mism = 1'b1;
        end
        chk({tag, " addr_beat_seq"}, 32'(mism), 32'd0);
        chk({tag, " first_beat_lat"}, 32'(dv_first - en_first), 32'd2);
        chk({tag, " done_with_last"}, 32'(done_cyc - dv_last), 32'd0);
        chk({tag, " done_lat"}, 32'(done_cyc - en_last), 32'd2);
        chk({tag, " done_once"}, 32'(n_done), 32'd1);
        chk({tag, " checksum"}, 32'(checksum), 32'(model_sum(f, l)));
        tick();
        chk({tag, " no_restart"}, 32'({busy, en, data_valid}), 32'd0);
        chk({tag, " count_hold"}, 32'(count), 32'(n));
        res_count = int'(count);
        res_sum   = checksum;
    endtask

    initial begin
        bit seen;
        logic [3:0] rf, rl;
        reset = 1'b1;
        start = 1'b0;
        first_addr = '0;
        last_addr  = '0;
        spec_mem();

        vecs[0] = '{first: 4'd0,  last: 4'd3,  exp_n: 4,  exp_sum: 8'h01};
        vecs[1] = '{first: 4'd14, last: 4'd1,  exp_n: 4,  exp_sum: 8'hF1};
        vecs[2] = '{first: 4'd15, last: 4'd15, exp_n: 1,  exp_sum: 8'h0F};
        vecs[3] = '{first: 4'd5,  last: 4'd5,  exp_n: 1,  exp_sum: 8'hFF};
        vecs[4] = '{first: 4'd1,  last: 4'd0,  exp_n: 16, exp_sum: 8'hF1};

        // Reset for two cycles, with start asserted to show it is ignored.
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        reset = 1'b0;
        chk("rst en", 32'(en), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst data_valid", 32'(data_valid), 32'd0);
        chk("rst count", 32'(count), 32'd0);
        chk("rst data_out", 32'(data_out), 32'd0);
        chk("rst checksum", 32'(checksum), 32'd0);
        chk("rst address", 32'(address), 32'd0);
        tick();

        foreach (vecs[i]) begin
            run_sweep(vecs[i].first, vecs[i].last, 1'b0, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d tbl_count", i), 32'(res_count), 32'(vecs[i].exp_n));
`ifdef SWEEP_CHECKSUM_EN
            chk($sformatf("vec%0d tbl_sum", i), 32'(res_sum), 32'(vecs[i].exp_sum));
`else
            chk($sformatf("vec%0d tbl_sum", i), 32'(res_sum), 32'd0);
`endif
        end

        // Start held high through the whole sweep, including the DONE cycle.
        run_sweep(4'd0, 4'd3, 1'b1, "hold_start");

        // Randomized sweeps over randomized memory contents.
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < 16; i++) mem_arr[i] = 8'($urandom);
            rf = 4'($urandom);
            rl = 4'($urandom);
            run_sweep(rf, rl, 1'($urandom), $sformatf("rnd%0d", k));
            repeat ($urandom_range(0, 2)) tick();
        end

        // Reset during the second ISSUE cycle of sweep 0..7.
        spec_mem();
        first_addr = 4'd0;
        last_addr  = 4'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("midrst second_issue_en", 32'(en), 32'd1);
        reset = 1'b1;
        start = 1'b1;
        tick();
        chk("midrst en", 32'(en), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst count", 32'(count), 32'd0);
        chk("midrst dv_done", 32'({data_valid, done}), 32'd0);
        chk("midrst data_out", 32'(data_out), 32'd0);
        chk("midrst checksum", 32'(checksum), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (data_valid || done || busy || en) seen = 1'b1;
        end
        chk("midrst quiet", 32'(seen), 32'd0);

        // Recovery after reset.
        run_sweep(4'd14, 4'd1, 1'b0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/addr_sweep_ctrl.md
ADDR_SWEEP_CTRL -- requirements
Module: addr_sweep_ctrl

Interface
REQ-001 Parameter ADDR_W, default 4, memory address width.
REQ-002 Parameter DATA_W, default 8, memory read data width.
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a sweep, sampled only in IDLE.
REQ-006 first_addr  input  ADDR_W  first address of sweep, sampled with start.
REQ-007 last_addr  input  ADDR_W  last address of sweep, sampled with start.
REQ-008 en  output  1  read enable to downstream lookup memory.
REQ-009 address  output  ADDR_W  read address to memory, meaningful only while en=1.
REQ-010 rd_data  input  DATA_W  memory registered output, valid the cycle after en.
REQ-011 data_valid  output  1  one-cycle strobe, data_out holds one captured beat.
REQ-012 data_out  output  DATA_W  registered captured read data.
REQ-013 busy  output  1  sweep in progress.
REQ-014 done  output  1  one-cycle pulse, sweep complete.
REQ-015 count  output  ADDR_W+1  beats captured in current/last sweep.
REQ-016 checksum  output  DATA_W  XOR of captured beats (see Configuration).

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT, DONE; reset state IDLE.
REQ-018 IDLE: start=1 SHALL latch first_addr into addr counter, clear count and checksum, go to ISSUE; busy=1 from next cycle.
REQ-019 ISSUE: en=1, address=addr counter each cycle; if addr==last_addr latched, go WAIT, else addr increments.
REQ-020 Address increment SHALL wrap modulo 2^ADDR_W; first>last sweeps through wrap (14..1 = 14,15,0,1).
REQ-021 first==last SHALL issue exactly one read; full sweep covers 1 to 2^ADDR_W beats.
REQ-022 en high in cycle T: rd_data sampled at end of T+1; data_valid=1 and data_out=sample in T+2; count increments in T+2.
REQ-023 WAIT SHALL last one cycle with en=0, then DONE.
REQ-024 DONE: done=1 for exactly one cycle, coincident with last data_valid; next state IDLE; busy=0 from the following cycle.
REQ-025 busy=1 in ISSUE, WAIT, DONE; start while busy (incl. DONE cycle) SHALL be ignored.
REQ-026 en SHALL be 0 in IDLE, WAIT, DONE; never two sweeps overlap.
REQ-027 count, data_out, checksum SHALL hold after done until next accepted start.
REQ-028 data_valid SHALL be 0 except in the beat cycles of REQ-022.

Reset
REQ-029 reset=1 at a rising edge SHALL force IDLE and en=0, busy=0, done=0, data_valid=0, address=0, data_out=0, count=0, checksum=0 from the next cycle.
REQ-030 Reset mid-sweep SHALL discard in-flight beats; no data_valid or done after reset.
REQ-031 start sampled during reset SHALL be ignored.

Configuration
REQ-032 Macro SWEEP_CHECKSUM_EN defined: checksum = XOR of all data_out values of current sweep, updated with each data_valid, cleared on accepted start.
REQ-033 Macro undefined: checksum port present, constant 0, no checksum register.

Verification
REQ-034 Reset 2 cycles -> en=0, busy=0, done=0, data_valid=0, count=0, data_out=0, checksum=0.
REQ-035 Memory model (0->00, 1->01, 15->0F, else FF); start, first=0, last=3 -> en 4 cycles addr 0,1,2,3; beats 00,01,FF,FF; done with last beat; count=4; checksum=01 (0 without macro).
REQ-036 first=14, last=1 -> addr E,F,0,1; beats FF,0F,00,01; count=4; checksum=F1.
REQ-037 first=last=15 -> one en cycle, one beat 0F, done in same cycle, count=1.
REQ-038 start pulsed every cycle during sweep first=0,last=3 -> exactly 4 beats, one done, no restart until IDLE.
REQ-039 reset during 2nd ISSUE cycle of sweep 0..7 -> next cycle en=0, busy=0, count=0; no further data_valid/done.
